// File: rtl/coef_sr_pkg.sv
// Shared definitions for the coefficient rotation register.
//   state_e        : controller states (idle / rotating)
//   MODE_*         : rotation mode encodings for the latched mode bit
//   plane_bit_idx  : flat bit index of coefficient bit within the bit-plane bus
package coef_sr_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic MODE_CYCLIC     = 1'b0;
    localparam logic MODE_NEGACYCLIC = 1'b1;

    // Bit `coef` of plane `plane` sits at plane*n + coef on the flat plane bus.
    function automatic int unsigned plane_bit_idx(input int unsigned plane,
                                                  input int unsigned coef,
                                                  input int unsigned n);
        return plane * n + coef;
    endfunction

endpackage

// File: rtl/coef_wrap_neg.sv
// Wrap-path unit: passes the top coefficient through, or its two's-complement
// negation (mod 2^W) when negacyclic rotation is selected.
//   data_i : W-bit coefficient leaving position N-1
//   neg_i  : 1 = negate
//   data_o : W-bit value entering position 0
module coef_wrap_neg #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] data_i,
    input  logic         neg_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] neg_val;

    // Wraps silently: negating the most negative value yields itself.
    assign neg_val = (~data_i) + W'(1);
    assign data_o  = neg_i ? neg_val : data_i;

endmodule

// File: rtl/coef_shift_reg.sv
// Coefficient rotation register for the polynomial multiplier.
// Loads N W-bit coefficients from W bit-planes, then rotates one position per
// step (cyclic or negacyclic), returning to idle with a done pulse after N steps.
// Optional feature macro: COEF_SR_NEGACYCLIC_EN (honour mode_i; else cyclic only).
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   in_valid_i  load request;   in_ready_o  can accept a load (idle)
//   in_planes_i bit-plane p at [p*N +: N], bit i = bit p of coefficient i
//   mode_i      0 cyclic, 1 negacyclic, sampled on load
//   step_i      advance one rotation while busy
//   clear_i     synchronous abort to idle (wins over step and load)
//   coef_o      coefficient i at [i*W +: W]
//   rot_cnt_o   rotations since last load
//   busy_o      rotation in progress;   done_o  one-cycle pulse after Nth step
module coef_shift_reg
    import coef_sr_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [W*N-1:0]      in_planes_i,
    input  logic                mode_i,
    input  logic                step_i,
    input  logic                clear_i,
    output logic [N*W-1:0]      coef_o,
    output logic [$clog2(N):0]  rot_cnt_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned CntW = $clog2(N) + 1;

    state_e                   state_q, state_d;
    logic [N-1:0][W-1:0]      coef_q, coef_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic                     done_q, done_d;
    logic [W-1:0]             wrap_val;
    logic                     load_mode;

`ifdef COEF_SR_NEGACYCLIC_EN
    coef_wrap_neg #(
        .W (W)
    ) u_wrap_neg (
        .data_i (coef_q[N-1]),
        .neg_i  (mode_q == MODE_NEGACYCLIC),
        .data_o (wrap_val)
    );
    assign load_mode = mode_i;
`else
    // Mode input and latched mode have no effect in the cyclic-only build.
    logic unused_mode;
    assign unused_mode = mode_i ^ mode_q;
    assign wrap_val    = coef_q[N-1];
    assign load_mode   = MODE_CYCLIC;
`endif

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (clear_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        for (int p = 0; p < int'(W); p++) begin
                            for (int i = 0; i < int'(N); i++) begin
                                coef_d[i][p] = in_planes_i[plane_bit_idx(p, i, N)];
                            end
                        end
                        mode_d  = load_mode;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (step_i) begin
                        for (int i = 1; i < int'(N); i++) begin
                            coef_d[i] = coef_q[i-1];
                        end
                        coef_d[0] = wrap_val;
                        cnt_d     = cnt_q + CntW'(1);
                        if (cnt_q == CntW'(N - 1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            coef_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_CYCLIC;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            coef_q  <= coef_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign in_ready_o = (state_q == StIdle);
    assign busy_o     = (state_q == StRun);
    assign coef_o     = coef_q;
    assign rot_cnt_o  = cnt_q;
    assign done_o     = done_q;

endmodule
